spi_master_tx: RTL
==================

Name: spi_master_tx

Overview:
- SPI initiator for the operand/operator link: drives CS, SCLK and MOSI, and reads MISO.
- Sends a handshake bit, waits for the responder's MISO confirmation, then shifts out a 12-bit frame MSB-first: [operando_1, operando_2, operador].
- It is the transmit end used when an FPGA, instead of the Arduino, feeds the SPI slave (for example a loop-back board or a simulation harness).
- It is controlled by a one-cycle start strobe and reports busy, done and a handshake-timeout error.

Parameters:
- CLK_DIV, 4: clk_arduino cycles per SCLK half-period; must be >= 2.
- HS_TIMEOUT, 16: maximum SCLK rising edges spent waiting for MISO=1 during the handshake.
- FIELD_W, 4: width of each field. The frame is 3*FIELD_W bits.

Ports:
- clk_arduino  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- operando_1  in  FIELD_W  first field; latched on an accepted start.
- operando_2  in  FIELD_W  second field; latched on an accepted start.
- operador  in  FIELD_W  third field; latched on an accepted start.
- MISO  in  1  responder confirmation line.
- SCLK  out  1  serial clock; idles low (CPOL=0).
- MOSI  out  1  serial data.
- CS  out  1  chip select, active low.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse marking the end of a frame (success or error).
- hs_error  out  1  sticky flag set on handshake timeout; cleared by the next accepted start.

Behaviour:
- Reset values: SCLK=0, MOSI=0, CS=1, busy=0, done=0, hs_error=0, state=IDLE. All outputs are registered.
- Reset asserted mid-frame: CS rises and SCLK falls immediately (asynchronously). No done pulse is produced.
- Half-period tick: a counter of 0..CLK_DIV-1 runs only outside IDLE and DONE and emits a tick when it wraps. Ticks alternate between SCLK rise and SCLK fall.
- MOSI changes only while SCLK is low. MISO is sampled on the clock cycle SCLK rises.
- IDLE:
  - On start=1, latch shift_reg={operando_1, operando_2, operador} and clear hs_error.
  - Next cycle: CS=0, MOSI=1, busy=1; go to SETUP.
  - start while not in IDLE is ignored.
- SETUP: wait one half-period with SCLK low, then go to HANDSHAKE.
- HANDSHAKE:
  - MOSI is held at 1 and SCLK toggles.
  - On each rise, increment hs_cnt. If MISO=1 at that rise, go to DATA at the following fall.
  - If hs_cnt reaches HS_TIMEOUT with MISO still 0, set hs_error=1 and go to HOLD.
  - MISO=1 on the very first rise is valid, e.g. a responder already confirmed from an earlier frame.
- DATA:
  - At the first fall, MOSI = shift_reg[MSB]. Each later fall shifts left and presents the next bit.
  - bit_cnt counts rises from 0 to 11. After the rise with bit_cnt=11, the next fall goes to HOLD.
  - Exactly 12 SCLK rises occur in DATA.
- HOLD: SCLK=0 and MOSI=0 for one half-period, then CS=1 and go to DONE.
- DONE: done=1 for exactly one cycle; busy=0 in the same cycle. Return to IDLE.
- start is accepted again on the cycle after DONE.
- Frame length on success with handshake confirmed on rise k (1-based): 2*CLK_DIV*(k+12) + 2*CLK_DIV + small constant cycles. The bench checks SCLK edge counts, not absolute cycles.
- Width rules:
  - hs_cnt is clog2(HS_TIMEOUT+1) bits.
  - bit_cnt is 4 bits, saturating at 11.
  - No arithmetic is performed on the field data.
- Boundary cases:
  - MISO glitches between rises are ignored.
  - MISO dropping during DATA is ignored.
  - start and reset asserted together: reset wins.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, SETUP, HANDSHAKE, DATA, HOLD, DONE);
  - FRAME_W = 3*FIELD_W;
  - the field order constants.
- One sub-module, spi_sclk_gen:
  - contains the half-period counter and SCLK register;
  - outputs rise_tick and fall_tick;
  - takes an enable input and is held in reset when disabled.

Test Plan:
- Normal frame: CLK_DIV=2; start with operando_1=4'hA, operando_2=4'h3, operador=4'h1; MISO tied to 1.
  - Expect 1 handshake rise, then 12 data rises with MOSI at the rises = 1010_0011_0001.
  - CS low for the whole frame, done pulses once, hs_error=0.
- Delayed confirmation: MISO rises after the 3rd SCLK rise.
  - Expect 4 handshake rises before data.
  - Data bits are correct and the total SCLK rises = 16.
- Timeout: HS_TIMEOUT=16, MISO held 0.
  - Expect exactly 16 SCLK rises with MOSI=1, then CS=1, hs_error=1 and one done pulse.
  - A following start with MISO=1 clears hs_error.
- start while busy: pulse start with new operands mid-DATA.
  - The frame is unchanged, there is no second frame, and exactly one done pulse occurs.
- Reset mid-DATA: assert reset after the 5th data rise.
  - CS=1 and SCLK=0 in the same cycle, no done pulse.
  - After release, the next start sends a full 12-bit frame.
- Back-to-back: start on the cycle after done.
  - The second frame is accepted; CS goes high for at least one cycle between frames.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI operand/operator transmitter.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HANDSHAKE,
    DATA,
    HOLD,
    DONE
  } state_t;

  localparam int FIELD_W_DEF = 4;
  localparam int NUM_FIELDS  = 3;

  // Field order in the frame, counted from the MSB end (first bit on the wire).
  localparam int FLD_OPERANDO_1 = 0;
  localparam int FLD_OPERANDO_2 = 1;
  localparam int FLD_OPERADOR   = 2;

  function automatic int frame_w(input int fw);
    return NUM_FIELDS * fw;
  endfunction

  // Bit position of a field's LSB inside the frame.
  function automatic int field_lsb(input int idx, input int fw);
    return (NUM_FIELDS - 1 - idx) * fw;
  endfunction

  localparam int FRAME_W = frame_w(FIELD_W_DEF);

endpackage

// File: rtl/spi_master_tx_if.sv
// Request/status and SPI pin bundle for the transmitter.
interface spi_master_tx_if
  import spi_pkg::*;
#(
  parameter int FIELD_W = FIELD_W_DEF
);
  logic               start;
  logic [FIELD_W-1:0] operando_1;
  logic [FIELD_W-1:0] operando_2;
  logic [FIELD_W-1:0] operador;
  logic               MISO;
  logic               SCLK;
  logic               MOSI;
  logic               CS;
  logic               busy;
  logic               done;
  logic               hs_error;

  modport master (
    input  start, operando_1, operando_2, operador, MISO,
    output SCLK, MOSI, CS, busy, done, hs_error
  );

  modport slave (
    output start, operando_1, operando_2, operador, MISO,
    input  SCLK, MOSI, CS, busy, done, hs_error
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period timer and SCLK register. Held cleared (SCLK low) when disabled;
// SCLK only toggles while run is high, so idle half-periods still tick.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_arduino,
  input  logic reset,
  input  logic en,
  input  logic run,
  output logic sclk,
  output logic half_tick,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign half_tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = half_tick && run && !sclk;
  assign fall_tick = half_tick && run && sclk;

  // Counter wraps every CLK_DIV cycles; SCLK flips on the wrap when running.
  always_ff @(posedge clk_arduino or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= half_tick ? '0 : cnt + 1'b1;
      if (half_tick && run) sclk <= !sclk;
    end
  end
endmodule

// File: rtl/spi_master_tx.sv
// SPI initiator: handshake bit with MISO confirmation, then a 3-field frame MSB-first.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int HS_TIMEOUT = 16,
  parameter int FIELD_W    = FIELD_W_DEF
) (
  input logic             clk_arduino,
  input logic             reset,
  spi_master_tx_if.master bus
);
  localparam int FRM_W = frame_w(FIELD_W);
  localparam int HS_W  = $clog2(HS_TIMEOUT + 1);
  localparam int BC_W  = $clog2(FRM_W);

  state_t           state;
  logic [FRM_W-1:0] shift_reg, frame;
  logic [HS_W-1:0]  hs_cnt;
  logic [BC_W-1:0]  bit_cnt;
  logic             hs_ok, last_bit;
  logic             cs, mosi, busy, done, hs_error;
  logic             sclk, half_tick, rise_tick, fall_tick;
  logic             en, run;

  assign en  = (state != IDLE) && (state != DONE);
  assign run = (state == HANDSHAKE) || (state == DATA);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk_arduino(clk_arduino),
    .reset      (reset),
    .en         (en),
    .run        (run),
    .sclk       (sclk),
    .half_tick  (half_tick),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick)
  );

  // Assemble the frame from the three fields in wire order.
  always_comb begin
    frame = '0;
    frame[field_lsb(FLD_OPERANDO_1, FIELD_W) +: FIELD_W] = bus.operando_1;
    frame[field_lsb(FLD_OPERANDO_2, FIELD_W) +: FIELD_W] = bus.operando_2;
    frame[field_lsb(FLD_OPERADOR,   FIELD_W) +: FIELD_W] = bus.operador;
  end

  // Frame sequencer; MISO is sampled on rise ticks, MOSI only moves on falls.
  always_ff @(posedge clk_arduino or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      hs_cnt    <= '0;
      bit_cnt   <= '0;
      hs_ok     <= 1'b0;
      last_bit  <= 1'b0;
      cs        <= 1'b1;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hs_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          shift_reg <= frame;
          hs_error  <= 1'b0;
          hs_cnt    <= '0;
          bit_cnt   <= '0;
          hs_ok     <= 1'b0;
          last_bit  <= 1'b0;
          cs        <= 1'b0;
          mosi      <= 1'b1;
          busy      <= 1'b1;
          state     <= SETUP;
        end
        SETUP: if (half_tick) state <= HANDSHAKE;
        HANDSHAKE: begin
          if (rise_tick) begin
            hs_cnt <= hs_cnt + 1'b1;
            // Confirmation wins over timeout on the same rise.
            if (bus.MISO) hs_ok <= 1'b1;
            else if (hs_cnt == HS_W'(HS_TIMEOUT - 1)) hs_error <= 1'b1;
          end else if (fall_tick) begin
            if (hs_ok) begin
              mosi  <= shift_reg[FRM_W-1];
              state <= DATA;
            end else if (hs_error) begin
              mosi  <= 1'b0;
              state <= HOLD;
            end
          end
        end
        DATA: begin
          if (rise_tick) begin
            if (bit_cnt == BC_W'(FRM_W - 1)) last_bit <= 1'b1;
            else bit_cnt <= bit_cnt + 1'b1;
          end else if (fall_tick) begin
            if (last_bit) begin
              mosi  <= 1'b0;
              state <= HOLD;
            end else begin
              shift_reg <= shift_reg << 1;
              mosi      <= shift_reg[FRM_W-2];
            end
          end
        end
        HOLD: if (half_tick) begin
          cs    <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SCLK     = sclk;
  assign bus.MOSI     = mosi;
  assign bus.CS       = cs;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.hs_error = hs_error;
endmodule
